// File: rtl/color_pipe_multi.sv
// rtl/color_pipe_multi.sv - multi-channel gamma/contrast/brightness pipeline with valid/ready handshake
module color_pipe_multi #(
    parameter int CH     = 3,
    parameter int DATA_W = 8,
    parameter int GAIN_W = 8,
    parameter int FRAC   = 6
) (
    input  logic                             clk,
    input  logic                             resetN,
    input  logic                             datapath_resetN,
    input  logic                             g_en,
    input  logic                             c_en,
    input  logic                             b_en,
    input  logic [GAIN_W-1:0]                contrast_gain,
    input  logic [DATA_W-1:0]                brightness_param,
    input  logic [CH*DATA_W-1:0]             pix_in,
    input  logic                             pix_in_valid,
    output logic                             pix_in_ready,
    output logic [CH*DATA_W-1:0]             pix_out,
    output logic                             pix_out_valid,
    input  logic                             pix_out_ready,
    input  logic                             lut_wr_en,
    input  logic [((CH>1)?$clog2(CH):1)-1:0] lut_wr_ch,
    input  logic [DATA_W-1:0]                lut_wr_addr,
    input  logic [DATA_W-1:0]                lut_wr_data,
    input  logic [((CH>1)?$clog2(CH):1)-1:0] lut_rd_ch,
    input  logic [DATA_W-1:0]                lut_rd_addr,
    output logic [DATA_W-1:0]                lut_rd_data
);

    localparam int DEPTH = 1 << DATA_W;
    localparam int MID   = 1 << (DATA_W - 1);
    localparam int MAXV  = DEPTH - 1;
    localparam int PW    = DATA_W + GAIN_W + 2;
    localparam int BW    = DATA_W + 2;

    logic [DATA_W-1:0]    lut [CH][DEPTH];
    logic [CH*DATA_W-1:0] s1_d, s2_d, s3_d;
    logic [CH*DATA_W-1:0] s1_q, s2_q, s3_q;
    logic                 v1, v2, v3;
    logic                 adv1, adv2, adv3;

    // Gain is applied about mid-grey; PW leaves headroom so the product never wraps.
    function automatic logic [DATA_W-1:0] contrast_f(input logic [DATA_W-1:0] x,
                                                     input logic [GAIN_W-1:0] g);
        logic signed [DATA_W:0] d;
        logic signed [PW-1:0]   p;
        logic signed [PW-1:0]   q;
        d = $signed({1'b0, x}) - $signed((DATA_W+1)'(MID));
        p = PW'(d) * $signed({{(PW-GAIN_W){1'b0}}, g});
        q = (p >>> FRAC) + PW'(MID);
        if (q < 0)
            return '0;
        else if (q > PW'(MAXV))
            return {DATA_W{1'b1}};
        else
            return q[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] bright_f(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] b);
        logic signed [BW-1:0] r;
        r = $signed({2'b00, x}) + BW'($signed(b));
        if (r < 0)
            return '0;
        else if (r > BW'(MAXV))
            return {DATA_W{1'b1}};
        else
            return r[DATA_W-1:0];
    endfunction

    assign adv3         = pix_out_ready | ~v3;
    assign adv2         = adv3 | ~v2;
    assign adv1         = adv2 | ~v1;
    assign pix_in_ready = adv1;
    assign pix_out      = s3_q;
    assign pix_out_valid = v3;

    assign lut_rd_data = (32'(lut_rd_ch) < CH) ? lut[lut_rd_ch][lut_rd_addr] : '0;

    always_comb begin
        s1_d = '0;
        s2_d = '0;
        s3_d = '0;
        for (int c = 0; c < CH; c++) begin
            s1_d[c*DATA_W +: DATA_W] = g_en ? lut[c][pix_in[c*DATA_W +: DATA_W]]
                                            : pix_in[c*DATA_W +: DATA_W];
            s2_d[c*DATA_W +: DATA_W] = c_en ? contrast_f(s1_q[c*DATA_W +: DATA_W], contrast_gain)
                                            : s1_q[c*DATA_W +: DATA_W];
            s3_d[c*DATA_W +: DATA_W] = b_en ? bright_f(s2_q[c*DATA_W +: DATA_W], brightness_param)
                                            : s2_q[c*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
            for (int c = 0; c < CH; c++)
                for (int a = 0; a < DEPTH; a++)
                    lut[c][a] <= DATA_W'(a);
        end else begin
            if (!datapath_resetN) begin
                v1 <= 1'b0;
                v2 <= 1'b0;
                v3 <= 1'b0;
            end else begin
                if (adv1) begin
                    v1   <= pix_in_valid;
                    s1_q <= s1_d;
                end
                if (adv2) begin
                    v2   <= v1;
                    s2_q <= s2_d;
                end
                if (adv3) begin
                    v3   <= v2;
                    s3_q <= s3_d;
                end
            end
            // LUT writes ignore stalls and flushes; stage 1 reads the pre-write entry on this edge.
            if (lut_wr_en && (32'(lut_wr_ch) < CH))
                lut[lut_wr_ch][lut_wr_addr] <= lut_wr_data;
        end
    end

endmodule
